// File: rtl/fir_tap_window.sv
// Sample delay line for a symmetric FIR: holds the last TAPS samples and
// presents them as one flattened window behind a valid/ready handshake.
module fir_tap_window #(
    parameter int W          = 12,
    parameter int TAPS       = 39,
    parameter int ZERO_PRIME = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [W-1:0]                 in_data,
    output logic                         in_ready,
    output logic [TAPS*W-1:0]            win_data,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic [$clog2(TAPS+1)-1:0]    fill_count
);

    localparam int CW = $clog2(TAPS + 1);

    logic [TAPS*W-1:0] taps_q, taps_d;
    logic [CW-1:0]     fill_q, fill_d;
    logic              win_valid_q, win_valid_d;
    logic              accept;
    logic              win_event;

    // Stalling the producer while a window is pending keeps win_data frozen.
    assign in_ready = !flush && (!win_valid_q || win_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        taps_d      = taps_q;
        fill_d      = fill_q;
        win_valid_d = win_valid_q;
        win_event   = 1'b0;
        if (flush) begin
            taps_d      = '0;
            fill_d      = '0;
            win_valid_d = 1'b0;
        end else begin
            if (accept) begin
                taps_d = {taps_q[(TAPS-1)*W-1:0], in_data};
                if (fill_q != CW'(TAPS)) begin
                    fill_d = fill_q + CW'(1);
                end
                win_event = (ZERO_PRIME != 0) || (fill_d == CW'(TAPS));
            end
            // A fresh window on the consuming edge keeps valid asserted.
            if (win_event) begin
                win_valid_d = 1'b1;
            end else if (win_valid_q && win_ready) begin
                win_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            taps_q      <= '0;
            fill_q      <= '0;
            win_valid_q <= 1'b0;
        end else begin
            taps_q      <= taps_d;
            fill_q      <= fill_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign win_data   = taps_q;
    assign win_valid  = win_valid_q;
    assign fill_count = fill_q;

endmodule

// File: tb/tb_fir_tap_window.sv
// Self-checking bench for fir_tap_window: one instance without and one with
// zero-primed history, both checked every cycle against a history-list model.
module tb_fir_tap_window;

    localparam int W    = 12;
    localparam int TAPS = 39;
    localparam int CW   = $clog2(TAPS + 1);
    localparam int DW   = TAPS * W;
    localparam int HMAX = 8192;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          win_ready;

    logic          in_ready0, win_valid0, in_ready1, win_valid1;
    logic [DW-1:0] win_data0, win_data1;
    logic [CW-1:0] fill0, fill1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: every sample accepted since the last clear, plus a pending flag.
    logic [W-1:0] hist [2][HMAX];
    int           hlen [2];
    bit           pend [2];
    bit           macc;

    always #5 clock = ~clock;

    fir_tap_window #(.W(W), .TAPS(TAPS), .ZERO_PRIME(0)) dut0 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
        .win_data(win_data0), .win_valid(win_valid0), .win_ready(win_ready),
        .fill_count(fill0)
    );

    fir_tap_window #(.W(W), .TAPS(TAPS), .ZERO_PRIME(1)) dut1 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .win_data(win_data1), .win_valid(win_valid1), .win_ready(win_ready),
        .fill_count(fill1)
    );

    function automatic bit expReady(int i);
        return !flush && (!pend[i] || win_ready);
    endfunction

    function automatic int expFill(int i);
        return (hlen[i] < TAPS) ? hlen[i] : TAPS;
    endfunction

    function automatic logic [DW-1:0] expWindow(int i);
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (k < hlen[i]) w[k*W +: W] = hist[i][hlen[i]-1-k];
        end
        return w;
    endfunction

    function automatic logic [W-1:0] tapOf(logic [DW-1:0] d, int k);
        return d[k*W +: W];
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                hlen[i] = 0;
                pend[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                macc = in_valid && expReady(i);
                if (flush) begin
                    hlen[i] = 0;
                    pend[i] = 1'b0;
                end else begin
                    if (macc && hlen[i] < HMAX) begin
                        hist[i][hlen[i]] = in_data;
                        hlen[i]++;
                    end
                    if (macc && (i == 1 || hlen[i] >= TAPS)) pend[i] = 1'b1;
                    else if (pend[i] && win_ready)           pend[i] = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        #2;
        if (!reset) begin
            checkOutput("dut0 in_ready",   DW'(in_ready0),  DW'(expReady(0)));
            checkOutput("dut0 win_valid",  DW'(win_valid0), DW'(pend[0]));
            checkOutput("dut0 fill_count", DW'(fill0),      DW'(expFill(0)));
            checkOutput("dut0 win_data",   win_data0,       expWindow(0));
            checkOutput("dut1 in_ready",   DW'(in_ready1),  DW'(expReady(1)));
            checkOutput("dut1 win_valid",  DW'(win_valid1), DW'(pend[1]));
            checkOutput("dut1 fill_count", DW'(fill1),      DW'(expFill(1)));
            checkOutput("dut1 win_data",   win_data1,       expWindow(1));
        end
    end

    // Drives inputs, lets one rising edge act on them, returns 3 units after
    // the following falling edge with the inputs still applied.
    task automatic applyStimulus(logic v, logic [W-1:0] d, logic wr, logic fl);
        in_valid  = v;
        in_data   = d;
        win_ready = wr;
        flush     = fl;
        @(negedge clock);
        #3;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] saved;
        logic [DW-1:0] five;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; win_ready = 1'b0;
        repeat (2) @(negedge clock);
        #3;
        checkOutput("reset fill_count", DW'(fill0), DW'(0));
        checkOutput("reset win_valid",  DW'(win_valid0), DW'(0));
        checkOutput("reset in_ready",   DW'(in_ready0), DW'(1));
        checkOutput("reset win_data",   win_data0, '0);
        reset = 1'b0;

        applyStimulus(1'b1, 12'd5, 1'b1, 1'b0);
        five = '0;
        five[W-1:0] = 12'd5;
        checkOutput("zp win_valid",   DW'(win_valid1), DW'(1));
        checkOutput("zp window",      win_data1, five);
        checkOutput("zp fill_count",  DW'(fill1), DW'(1));
        checkOutput("nozp win_valid", DW'(win_valid0), DW'(0));

        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        reset = 1'b0;

        for (int s = 1; s <= 39; s++) begin
            applyStimulus(1'b1, W'(s), 1'b1, 1'b0);
            if (s == 38) checkOutput("fill38 win_valid", DW'(win_valid0), DW'(0));
        end
        checkOutput("full win_valid",  DW'(win_valid0), DW'(1));
        checkOutput("full tap0",       DW'(tapOf(win_data0, 0)), DW'(39));
        checkOutput("full tap38",      DW'(tapOf(win_data0, 38)), DW'(1));
        checkOutput("full fill_count", DW'(fill0), DW'(39));
        checkOutput("full in_ready",   DW'(in_ready0), DW'(1));

        for (int s = 40; s <= 45; s++) applyStimulus(1'b1, W'(s), 1'b1, 1'b0);
        checkOutput("stream tap0",  DW'(tapOf(win_data0, 0)), DW'(45));
        checkOutput("stream tap38", DW'(tapOf(win_data0, 38)), DW'(7));

        saved = win_data0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 12'd100, 1'b0, 1'b0);
            checkOutput("stall in_ready", DW'(in_ready0), DW'(0));
            checkOutput("stall win_data", win_data0, saved);
        end
        applyStimulus(1'b1, 12'd100, 1'b1, 1'b0);
        checkOutput("release tap0", DW'(tapOf(win_data0, 0)), DW'(100));
        checkOutput("release tap1", DW'(tapOf(win_data0, 1)), DW'(45));

        applyStimulus(1'b1, 12'd7, 1'b1, 1'b1);
        checkOutput("flush fill_count", DW'(fill0), DW'(0));
        checkOutput("flush win_data",   win_data0, '0);
        checkOutput("flush win_valid",  DW'(win_valid0), DW'(0));
        applyStimulus(1'b1, 12'd7, 1'b1, 1'b0);
        checkOutput("resend fill_count", DW'(fill0), DW'(1));
        checkOutput("resend win_valid",  DW'(win_valid0), DW'(0));
        checkOutput("resend tap0",       DW'(tapOf(win_data0, 0)), DW'(7));

        for (int s = 1; s <= 19; s++) applyStimulus(1'b1, W'(200 + s), 1'b1, 1'b0);
        checkOutput("fill20 fill_count", DW'(fill0), DW'(20));
        in_valid = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async fill_count",  DW'(fill0), DW'(0));
        checkOutput("async win_valid",   DW'(win_valid0), DW'(0));
        checkOutput("async win_data",    win_data0, '0);
        checkOutput("async zp win_valid", DW'(win_valid1), DW'(0));
        #1;
        reset = 1'b0;
        @(negedge clock);
        #3;

        for (int s = 1; s <= 39; s++) begin
            applyStimulus(1'b1, W'(300 + s), 1'b1, 1'b0);
            if (s == 38) begin
                checkOutput("refill38 win_valid",  DW'(win_valid0), DW'(0));
                checkOutput("refill38 fill_count", DW'(fill0), DW'(38));
            end
        end
        checkOutput("refill win_valid", DW'(win_valid0), DW'(1));
        checkOutput("refill tap0",      DW'(tapOf(win_data0, 0)), DW'(339));

        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, W'($urandom),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end

        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_tap_window.md
Name: fir_tap_window

Overview:
- Sample delay line that feeds the 39-tap symmetric FIR combinational stage.
- Accepts one binary sample per handshake and keeps the last TAPS samples in a shift register.
- Presents the full window as a flattened bus, with a valid/ready handshake toward the consumer that registers the FIR result.
- Tracks fill level, supports flush, and optionally emits windows from the first sample using zero-filled history.

Parameters:
- W, 12, sample width in bits (two's-complement not interpreted; stored raw).
- TAPS, 39, window length; must be >= 2.
- ZERO_PRIME, 0, 1 = emit a window for every accepted sample from the first one (history is zero); 0 = emit only once TAPS samples are held.

Ports:
- clock  in  1  sampling clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of taps and fill count.
- in_valid  in  1  upstream sample valid.
- in_data  in  W  upstream sample.
- in_ready  out  1  block can accept in_data this cycle.
- win_data  out  TAPS*W  window; slice k (bits (k+1)*W-1 : k*W) = tap k; tap 0 newest, tap TAPS-1 oldest.
- win_valid  out  1  window pending for consumer.
- win_ready  in  1  consumer takes window this cycle.
- fill_count  out  $clog2(TAPS+1)  samples held, saturating at TAPS.

Behaviour:
- Reset (async, active-high): all taps=0, fill_count=0, win_valid=0. in_ready=1 once reset deasserts (combinational from state).
- Accept: a sample is accepted at a clock edge where in_valid && in_ready.
- Shift on accept: tap[k] <= tap[k-1] for k=1..TAPS-1, tap[0] <= in_data. The oldest sample is discarded. Taps never change without an accept or a flush.
- fill_count: +1 per accept, saturating at TAPS.
- Window event on accept: fill_count_next==TAPS, or ZERO_PRIME=1.
  - A window event sets win_valid on the same edge.
  - win_data shows the post-shift taps from the following cycle.
  - Latency: sample accepted at edge t, window visible and valid in cycle t+1.
- win_valid clear: on an edge with win_valid && win_ready, unless a new window event occurs on that same edge, in which case it stays 1.
- in_ready = !flush && (!win_valid || win_ready).
  - Back-to-back accept and consume is sustained at 1 sample/clock.
  - While the consumer stalls, in_ready=0, so taps and win_data are frozen and stable for the whole time win_valid is high.
- States, derived from fill_count:
  - EMPTY (0).
  - FILLING (1..TAPS-1): no window events when ZERO_PRIME=0.
  - FULL (TAPS).
  - Transitions: EMPTY->FILLING on first accept; FILLING->FULL on the TAPS-th accept; any state->EMPTY on flush.
- flush (synchronous, highest priority): taps=0, fill_count=0, win_valid=0 at the edge. in_ready=0 during the flush cycle, so a simultaneous in_valid sample is not accepted (upstream holds it). A pending window is dropped without a handshake.
- Reset asserted mid-stall or mid-fill: state clears immediately, no partial window is ever presented.
- No arithmetic on data; widths are preserved exactly. fill_count never exceeds TAPS.

Test Plan:
- Reset then fill, ZERO_PRIME=0, win_ready=1: feed 1..39 one per clock. win_valid first high the cycle after sample 39; tap0=39, tap38=1; fill_count=39; in_ready stays 1.
- Steady streaming: continue with 40..45, win_ready=1. win_valid high each cycle; after 45, tap0=45, tap38=7; one window per sample, none lost or duplicated.
- Backpressure: with window full, hold win_ready=0 for 5 cycles while in_valid=1 with data 100. in_ready=0 and win_data unchanged for all 5 cycles. Raise win_ready: 100 is accepted on that edge and tap0=100 the next cycle.
- Flush with simultaneous in_valid (data 7): next cycle fill_count=0, all taps 0, win_valid=0, and 7 was not accepted. Resend 7: fill_count=1, win_valid=0.
- ZERO_PRIME=1 from reset: feed 5. Next cycle win_valid=1, tap0=5, taps1..38=0, fill_count=1.
- Async reset pulse between clock edges during FILLING (fill_count=20): outputs clear immediately without a clock edge, with fill_count=0 and win_valid=0. The next 39 samples are needed before any window when ZERO_PRIME=0.
